data_sram_ctrl: RTL and testbench
=================================

// Module: data_sram_ctrl
// PURPOSE
// - Responder for the CPU MEM-stage data port: takes addr/wdata/we/re/mask from the MEM stage and runs one
//   access cycle on an external asynchronous 32-bit SRAM with byte enables.
// - Byte-lane steering: the MEM-stage mask and data are right-aligned, and the controller shifts them by addr[1:0].
// - Stalls the pipeline until the access completes, then returns right-aligned read data for MEM to extend.
// PARAMETERS
// - ADDR_WIDTH   20  SRAM word-address width; SRAM address = mem_addr_i[ADDR_WIDTH+1:2]
// - READ_WAIT    2   cycles the SRAM read strobes stay active before data is sampled (>=1)
// - WRITE_PULSE  2   cycles sram_we_n_o is held low (>=1)
// PORTS
// - clk            in   1   system clock; all state updates on rising edge
// - rst            in   1   synchronous, active-high reset (rst == `ENABLE)
// - mem_addr_i     in   32  byte address from MEM stage
// - mem_data_i     in   32  right-aligned write data
// - mem_we_i       in   1   write request
// - mem_re_i       in   1   read request
// - mem_mask_i     in   4   right-aligned lane mask: 0001 byte, 0011 half, 1111 word
// - mem_data_o     out  32  right-aligned read data, valid in DONE cycle, held until next read completes
// - stall_o        out  1   pipeline stall request
// - sram_addr_o    out  ADDR_WIDTH  SRAM word address
// - sram_data_o    out  32  lane-shifted write data
// - sram_data_i    in   32  SRAM read bus
// - sram_data_oe_o out  1   1 = controller drives the SRAM data bus
// - sram_ce_n_o / sram_oe_n_o / sram_we_n_o  out 1 each  active-low strobes
// - sram_be_n_o    out  4   active-low byte enables (~(mask << addr[1:0]))
// BEHAVIOUR
// - Reset values: mem_data_o=0, stall_o=0, all sram_*_n=1, sram_be_n_o=4'hF, sram_data_oe_o=0, sram_addr_o=0,
//   sram_data_o=0. FSM goes to IDLE. Reset aborts any access mid-operation: strobes are high after that edge.
// - req = mem_we_i | mem_re_i. If both are set, the access is a write.
// - stall_o = req & (state != DONE). The stall is combinational, so it rises in the same cycle the request appears.
// - The MEM stage holds all request inputs stable while stall_o=1. They are latched at IDLE exit.
// - FSM:
//   - IDLE:  on req, latch addr/lanes/wdata, then go to READ or WR_SETUP.
//   - READ:  ce_n=0, oe_n=0, be_n active for READ_WAIT cycles. On the last cycle, sample sram_data_i, shift right by
//     8*addr[1:0], then go to DONE.
//   - WR_SETUP (1 cycle): data_oe=1, ce_n=0, we_n=1, then go to WR_PULSE.
//   - WR_PULSE: we_n=0 for WRITE_PULSE cycles, then go to WR_HOLD.
//   - WR_HOLD (1 cycle): we_n=1, data still driven, then go to DONE.
//   - DONE (1 cycle): all strobes inactive, stall_o=0 so the pipeline advances, then go to IDLE.
// - Latency from request cycle to DONE: read = 1+READ_WAIT cycles; write = 3+WRITE_PULSE cycles.
// - Back-to-back requests: a request present in the cycle after DONE starts a new access. There is no bubble beyond
//   the DONE cycle.
// - Lane rules: be = mask << addr[1:0] (4 bits, overflow discarded); sram_data_o = wdata << 8*addr[1:0].
// - Lanes not enabled on a read are don't-care in mem_data_o above the mask width. The MEM stage masks or extends them.
// - The write down-counter loads on state entry. The data bus is never driven while oe_n=0.
// CONFIGURATION
// - DATA_SRAM_ALIGN_CHECK_EN defined:
//   - A misaligned request (half with addr[0]=1, word with addr[1:0]!=0) makes no SRAM access.
//   - The FSM goes IDLE->DONE, with stall_o high for exactly 1 cycle.
//   - Extra output addr_err_o (1 bit) is high in that DONE cycle; mem_data_o=0. addr_err_o resets to 0.
// - Not defined: no addr_err_o port. Misaligned requests run normally; lanes shifted past bit 3 are dropped.
// TESTING
// - Reset: assert rst 2 cycles during WR_PULSE -> next edge we_n=1, ce_n=1, oe=0, stall_o=0, state IDLE.
// - LW: re=1, addr=0x100, mask=1111, SRAM word 0xDEADBEEF, READ_WAIT=2 -> stall_o high 3 cycles;
//   sram_addr=0x40; mem_data_o=0xDEADBEEF in DONE.
// - SB: we=1, addr=0x203, mask=0001, data=0x000000A5 -> be_n=0111, sram_data_o=0xA5000000;
//   we_n low for exactly WRITE_PULSE cycles.
// - LH: addr=0x302, SRAM word 0x8001_1234 -> mem_data_o[15:0]=0x8001, be_n=0011.
// - Back-to-back SW then LW, same address 0x10, data 0x12345678 -> LW returns 0x12345678;
//   stall low only in the two DONE cycles.
// - With DATA_SRAM_ALIGN_CHECK_EN: LW at addr 0x102 -> no ce_n pulse, 1-cycle stall, addr_err_o=1, mem_data_o=0.

Source files
------------

// File: rtl/data_sram_ctrl.sv
// data_sram_ctrl
//   Responder for the CPU MEM-stage data port. It runs one access cycle on an
//   external asynchronous 32-bit SRAM with active-low byte enables. It stalls
//   the pipeline until the access completes.
//   The MEM-stage mask and data arrive right-aligned. This block shifts them
//   onto the byte lanes selected by addr[1:0]. Read data is shifted back down
//   so that MEM can extend it.
//
// Optional feature macro: DATA_SRAM_ALIGN_CHECK_EN
//   When this macro is defined, a misaligned half or word request makes no
//   SRAM access. Instead the block reports the fault on addr_err_o.
//
// Ports
//   clk, rst        system clock; synchronous active-high reset
//   mem_addr_i      byte address from MEM
//   mem_data_i      right-aligned write data
//   mem_we_i        write request (a write wins when both requests are set)
//   mem_re_i        read request
//   mem_mask_i      right-aligned lane mask (0001 byte, 0011 half, 1111 word)
//   mem_data_o      right-aligned read data; updated when a read completes
//   stall_o         pipeline stall (combinational)
//   sram_addr_o     SRAM word address
//   sram_data_o     lane-shifted write data
//   sram_data_i     SRAM read bus
//   sram_data_oe_o  1 = controller drives the SRAM data bus
//   sram_ce_n_o, sram_oe_n_o, sram_we_n_o  active-low strobes
//   sram_be_n_o     active-low byte enables
//   addr_err_o      misaligned-request flag (only with DATA_SRAM_ALIGN_CHECK_EN)

module data_sram_ctrl #(
    parameter int ADDR_WIDTH  = 20,
    parameter int READ_WAIT   = 2,
    parameter int WRITE_PULSE = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           mem_addr_i,
    input  logic [31:0]           mem_data_i,
    input  logic                  mem_we_i,
    input  logic                  mem_re_i,
    input  logic [3:0]            mem_mask_i,
    output logic [31:0]           mem_data_o,
    output logic                  stall_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_data_o,
    input  logic [31:0]           sram_data_i,
    output logic                  sram_data_oe_o,
    output logic                  sram_ce_n_o,
    output logic                  sram_oe_n_o,
    output logic                  sram_we_n_o,
    output logic [3:0]            sram_be_n_o
`ifdef DATA_SRAM_ALIGN_CHECK_EN
    ,
    output logic                  addr_err_o
`endif
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_READ     = 3'd1;
    localparam logic [2:0] S_WR_SETUP = 3'd2;
    localparam logic [2:0] S_WR_PULSE = 3'd3;
    localparam logic [2:0] S_WR_HOLD  = 3'd4;
    localparam logic [2:0] S_DONE     = 3'd5;

    // The counter holds "cycles remaining minus one". It therefore only needs
    // to reach max(READ_WAIT, WRITE_PULSE) - 1.
    localparam int CNT_MAX = (READ_WAIT > WRITE_PULSE) ? READ_WAIT : WRITE_PULSE;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CW-1:0] RD_LOAD = CW'(READ_WAIT - 1);
    localparam logic [CW-1:0] WR_LOAD = CW'(WRITE_PULSE - 1);

    logic [2:0]    state;
    logic [2:0]    state_nxt;
    logic [CW-1:0] cnt;
    logic [1:0]    off_q;
    logic          req;
    logic [1:0]    off_in;
    logic [3:0]    be_in;
    logic          nxt_rd;
    logic          nxt_wr;
    logic          unused_addr_bits;

    assign req    = mem_we_i | mem_re_i;
    assign off_in = mem_addr_i[1:0];
    // Lanes shifted past bit 3 are discarded.
    assign be_in  = 4'(mem_mask_i << off_in);

    assign unused_addr_bits = ^mem_addr_i[31:ADDR_WIDTH+2];

`ifdef DATA_SRAM_ALIGN_CHECK_EN
    logic misaligned;
    assign misaligned = ((mem_mask_i == 4'b0011) && off_in[0]) ||
                        ((mem_mask_i == 4'b1111) && (off_in != 2'b00));
`endif

    // The stall is forced low during reset so that the reset value is visible
    // even while MEM keeps its request asserted.
    assign stall_o = req & (state != S_DONE) & ~rst;

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (req) begin
`ifdef DATA_SRAM_ALIGN_CHECK_EN
                    if (misaligned)    state_nxt = S_DONE;
                    else
`endif
                    if (mem_we_i)      state_nxt = S_WR_SETUP;
                    else               state_nxt = S_READ;
                end
            end
            S_READ:     if (cnt == '0) state_nxt = S_DONE;
            S_WR_SETUP:                state_nxt = S_WR_PULSE;
            S_WR_PULSE: if (cnt == '0) state_nxt = S_WR_HOLD;
            S_WR_HOLD:                 state_nxt = S_DONE;
            S_DONE:                    state_nxt = S_IDLE;
            default:                   state_nxt = S_IDLE;
        endcase
    end

    assign nxt_rd = (state_nxt == S_READ);
    assign nxt_wr = (state_nxt == S_WR_SETUP) || (state_nxt == S_WR_PULSE) ||
                    (state_nxt == S_WR_HOLD);

    // The strobes are registered from the next state. They therefore change
    // cleanly on the clock edge that enters each state. The read strobes and
    // the bus drive are never both active.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            cnt            <= '0;
            off_q          <= '0;
            mem_data_o     <= '0;
            sram_addr_o    <= '0;
            sram_data_o    <= '0;
            sram_data_oe_o <= 1'b0;
            sram_ce_n_o    <= 1'b1;
            sram_oe_n_o    <= 1'b1;
            sram_we_n_o    <= 1'b1;
            sram_be_n_o    <= 4'hF;
`ifdef DATA_SRAM_ALIGN_CHECK_EN
            addr_err_o     <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            sram_ce_n_o    <= ~(nxt_rd | nxt_wr);
            sram_oe_n_o    <= ~nxt_rd;
            sram_we_n_o    <= ~(state_nxt == S_WR_PULSE);
            sram_data_oe_o <= nxt_wr;

            if (!(nxt_rd | nxt_wr))
                sram_be_n_o <= 4'hF;
            else if (state == S_IDLE)
                sram_be_n_o <= ~be_in;

            if ((state == S_IDLE) && req) begin
                off_q       <= off_in;
                sram_addr_o <= mem_addr_i[ADDR_WIDTH+1:2];
                sram_data_o <= mem_data_i << {off_in, 3'b000};
            end

            // The counter loads on entry to READ (from IDLE) and on entry to
            // WR_PULSE (from WR_SETUP). In all other states it only counts down.
            if (state == S_IDLE)
                cnt <= RD_LOAD;
            else if (state == S_WR_SETUP)
                cnt <= WR_LOAD;
            else if (cnt != '0)
                cnt <= cnt - CW'(1);

            if ((state == S_READ) && (cnt == '0))
                mem_data_o <= sram_data_i >> {off_q, 3'b000};

`ifdef DATA_SRAM_ALIGN_CHECK_EN
            addr_err_o <= (state == S_IDLE) && req && misaligned;
            if ((state == S_IDLE) && req && misaligned)
                mem_data_o <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_data_sram_ctrl.sv
// Testbench for data_sram_ctrl. It combines directed cases with randomized
// requests. A byte-array reference model supplies the expected read data.
// A scoreboard queue holds the expected response of each access. The monitor
// checks that response in the cycle where stall_o drops.
// The DATA_SRAM_ALIGN_CHECK_EN macro also applies to this bench.

module tb_data_sram_ctrl;

    localparam int AW = 20;
    localparam int RW = 2;
    localparam int WP = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   mem_addr_i;
    logic [31:0]   mem_data_i;
    logic          mem_we_i;
    logic          mem_re_i;
    logic [3:0]    mem_mask_i;
    logic [31:0]   mem_data_o;
    logic          stall_o;
    logic [AW-1:0] sram_addr_o;
    logic [31:0]   sram_data_o;
    logic [31:0]   sram_data_i;
    logic          sram_data_oe_o;
    logic          sram_ce_n_o;
    logic          sram_oe_n_o;
    logic          sram_we_n_o;
    logic [3:0]    sram_be_n_o;
`ifdef DATA_SRAM_ALIGN_CHECK_EN
    logic          addr_err_o;
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    always #5 clk = ~clk;

    data_sram_ctrl #(
        .ADDR_WIDTH (AW),
        .READ_WAIT  (RW),
        .WRITE_PULSE(WP)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mem_addr_i    (mem_addr_i),
        .mem_data_i    (mem_data_i),
        .mem_we_i      (mem_we_i),
        .mem_re_i      (mem_re_i),
        .mem_mask_i    (mem_mask_i),
        .mem_data_o    (mem_data_o),
        .stall_o       (stall_o),
        .sram_addr_o   (sram_addr_o),
        .sram_data_o   (sram_data_o),
        .sram_data_i   (sram_data_i),
        .sram_data_oe_o(sram_data_oe_o),
        .sram_ce_n_o   (sram_ce_n_o),
        .sram_oe_n_o   (sram_oe_n_o),
        .sram_we_n_o   (sram_we_n_o),
        .sram_be_n_o   (sram_be_n_o)
`ifdef DATA_SRAM_ALIGN_CHECK_EN
        ,
        .addr_err_o    (addr_err_o)
`endif
    );

    // SRAM device model: 1024 words. It writes on any cycle where ce_n and
    // we_n are both low, and it drives read data while ce_n and oe_n are low.
    logic [31:0] sram_mem [0:1023];
    assign sram_data_i = (!sram_ce_n_o && !sram_oe_n_o) ? sram_mem[sram_addr_o[9:0]] : 32'h0;

    always @(negedge clk) begin
        if (!sram_ce_n_o && !sram_we_n_o)
            for (int i = 0; i < 4; i++)
                if (!sram_be_n_o[i])
                    sram_mem[sram_addr_o[9:0]][8*i +: 8] <= sram_data_o[8*i +: 8];
    end

    // Reference model: one flat byte array indexed by byte address.
    logic [7:0] ref_mem [0:4095];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    typedef struct {
        bit          is_rd;
        bit          err;
        logic [31:0] exp_data;
        logic [31:0] data_mask;
        logic [31:0] exp_wdata;
        logic [31:0] lane_mask;
        logic [19:0] exp_addr;
        logic [3:0]  exp_be_n;
        int unsigned exp_lat;
    } exp_t;

    exp_t sb[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_sim();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    endtask

    // Monitor state, accumulated between successive DONE cycles.
    int unsigned m_stall, m_ce, m_oe, m_we, m_clash;
    logic [19:0] m_addr;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;

    task automatic mon_clear();
        m_stall = 0; m_ce = 0; m_oe = 0; m_we = 0; m_clash = 0;
        m_addr = '0; m_be = 4'hF; m_wdata = '0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            mon_clear();
        end else begin
            if (!sram_ce_n_o) begin
                m_ce++;
                m_addr = sram_addr_o;
                m_be   = sram_be_n_o;
            end
            if (!sram_oe_n_o) m_oe++;
            if (!sram_we_n_o) begin
                m_we++;
                m_wdata = sram_data_o;
            end
            if (sram_data_oe_o && !sram_oe_n_o) m_clash++;

            if ((mem_we_i | mem_re_i) && stall_o) begin
                m_stall++;
            end else if ((mem_we_i | mem_re_i) && !stall_o) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL sb_empty: DONE seen with no access outstanding (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("stall_cycles", m_stall, e.exp_lat);
                    check("bus_clash", m_clash, 0);
                    if (e.err) begin
                        check("err_ce_cycles", m_ce, 0);
                        check("err_data", mem_data_o, 32'h0);
`ifdef DATA_SRAM_ALIGN_CHECK_EN
                        check("addr_err", {31'h0, addr_err_o}, 32'h1);
`endif
                    end else begin
                        check("sram_addr", {12'h0, m_addr}, {12'h0, e.exp_addr});
                        check("be_n", {28'h0, m_be}, {28'h0, e.exp_be_n});
`ifdef DATA_SRAM_ALIGN_CHECK_EN
                        check("addr_err", {31'h0, addr_err_o}, 32'h0);
`endif
                        if (e.is_rd) begin
                            check("rd_ce_cycles", m_ce, RW);
                            check("rd_oe_cycles", m_oe, RW);
                            check("rd_we_cycles", m_we, 0);
                            check("rd_data", mem_data_o & e.data_mask, e.exp_data & e.data_mask);
                        end else begin
                            check("wr_ce_cycles", m_ce, 2 + WP);
                            check("wr_oe_cycles", m_oe, 0);
                            check("wr_we_cycles", m_we, WP);
                            check("wr_data", m_wdata & e.lane_mask, e.exp_wdata & e.lane_mask);
                        end
                    end
                end
                mon_clear();
            end
        end
    end

    // Builds the expected response and updates the reference model.
    // It then presents the request and waits for its DONE cycle.
    // Call this one time unit after a rising edge.
    task automatic issue(input bit we, input bit re, input logic [31:0] addr,
                         input logic [3:0] mask, input logic [31:0] data);
        exp_t        e;
        int unsigned off, nb;
        bit          mis, done;
        logic [7:0]  lanes;
        off   = addr[1:0];
        nb    = (mask == 4'b1111) ? 4 : (mask == 4'b0011) ? 2 : 1;
        mis   = ((nb == 2) && addr[0]) || ((nb == 4) && (off != 0));
        lanes = {4'h0, mask} << off;
        e.is_rd     = !we;
        e.err       = ALIGN && mis;
        e.exp_addr  = addr[21:2];
        e.exp_be_n  = ~lanes[3:0];
        e.exp_data  = '0;
        e.data_mask = '0;
        e.exp_wdata = '0;
        e.lane_mask = '0;
        if (e.err) begin
            e.exp_lat   = 1;
            e.data_mask = '1;
        end else begin
            e.exp_lat = we ? 3 + WP : 1 + RW;
            for (int k = 0; k < 4; k++) begin
                if ((k < int'(nb)) && (int'(off) + k < 4)) begin
                    if (we) begin
                        ref_mem[int'(addr[11:0]) + k]       = data[8*k +: 8];
                        e.exp_wdata[8*(int'(off)+k) +: 8]   = data[8*k +: 8];
                        e.lane_mask[8*(int'(off)+k) +: 8]   = 8'hFF;
                    end else begin
                        e.exp_data[8*k +: 8]  = ref_mem[int'(addr[11:0]) + k];
                        e.data_mask[8*k +: 8] = 8'hFF;
                    end
                end
            end
        end
        sb.push_back(e);
        mem_we_i   = we;
        mem_re_i   = re;
        mem_addr_i = addr;
        mem_mask_i = mask;
        mem_data_i = data;
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            @(negedge clk);
            if (!stall_o) done = 1'b1;
        end
        if (!done) begin
            n_cmp++;
            n_bad++;
            $display("FAIL timeout: stall_o still high after 64 cycles at addr %h", addr);
            finish_sim();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int unsigned n);
        mem_we_i = 1'b0;
        mem_re_i = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic preload(input int unsigned word, input logic [31:0] v);
        sram_mem[word] = v;
        for (int k = 0; k < 4; k++) ref_mem[word*4 + k] = v[8*k +: 8];
    endtask

    function automatic logic [3:0] pick_mask(input int unsigned r);
        case (r)
            0:       return 4'b0001;
            1:       return 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    initial begin
        bit          seen;
        logic [31:0] a;
        logic [31:0] d;
        int unsigned r;

        rst        = 1'b1;
        mem_we_i   = 1'b0;
        mem_re_i   = 1'b0;
        mem_addr_i = '0;
        mem_data_i = '0;
        mem_mask_i = '0;
        mon_clear();
        for (int unsigned w = 0; w < 1024; w++) preload(w, $urandom());

        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_data", mem_data_o, 32'h0);
        check("rst_stall", {31'h0, stall_o}, 32'h0);
        check("rst_strobes", {29'h0, sram_ce_n_o, sram_oe_n_o, sram_we_n_o}, 32'h7);
        check("rst_be_n", {28'h0, sram_be_n_o}, 32'hF);
        check("rst_data_oe", {31'h0, sram_data_oe_o}, 32'h0);
        check("rst_sram_addr", {12'h0, sram_addr_o}, 32'h0);
        check("rst_sram_data", sram_data_o, 32'h0);
        rst = 1'b0;
        idle(1);

        // LW of a word
        preload(32'h40, 32'hDEADBEEF);
        issue(1'b0, 1'b1, 32'h100, 4'b1111, 32'h0);
        idle(1);
        // SB to the top lane
        issue(1'b1, 1'b0, 32'h203, 4'b0001, 32'h000000A5);
        idle(1);
        // LH of the upper half
        preload(32'hC0, 32'h80011234);
        issue(1'b0, 1'b1, 32'h302, 4'b0011, 32'h0);
        idle(1);
        // Back-to-back SW then LW to the same word
        issue(1'b1, 1'b0, 32'h10, 4'b1111, 32'h12345678);
        issue(1'b0, 1'b1, 32'h10, 4'b1111, 32'h0);
        idle(1);
        // Read back the SB target through the SRAM model
        issue(1'b0, 1'b1, 32'h203, 4'b0001, 32'h0);
        idle(1);

        // Reset in the middle of a write pulse. The model has already
        // committed the word once we_n was seen low.
        d = $urandom();
        for (int k = 0; k < 4; k++) ref_mem[32'h80 + k] = d[8*k +: 8];
        mem_we_i   = 1'b1;
        mem_re_i   = 1'b0;
        mem_addr_i = 32'h80;
        mem_mask_i = 4'b1111;
        mem_data_i = d;
        seen = 1'b0;
        for (int c = 0; c < 16 && !seen; c++) begin
            @(negedge clk);
            if (!sram_we_n_o) seen = 1'b1;
        end
        check("we_pulse_seen", {31'h0, seen}, 32'h1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_we_n", {31'h0, sram_we_n_o}, 32'h1);
        check("abort_ce_n", {31'h0, sram_ce_n_o}, 32'h1);
        check("abort_data_oe", {31'h0, sram_data_oe_o}, 32'h0);
        check("abort_stall", {31'h0, stall_o}, 32'h0);
        @(posedge clk);
        #1;
        rst      = 1'b0;
        mem_we_i = 1'b0;
        idle(1);
        issue(1'b0, 1'b1, 32'h80, 4'b1111, 32'h0);
        idle(1);

        // A misaligned word load (an address fault when the check is enabled)
        issue(1'b0, 1'b1, 32'h102, 4'b1111, 32'h0);
        idle(1);

        // Randomized traffic: reads, writes, and both requests set together
        // (a write). Gaps of zero cycles give back-to-back accesses.
        for (int n = 0; n < 300; n++) begin
            a        = $urandom();
            a[21:12] = '0;
            d        = $urandom();
            r        = $urandom_range(0, 3);
            issue(r >= 2, (r != 2), a, pick_mask($urandom_range(0, 2)), d);
            idle($urandom_range(0, 2));
        end

        idle(3);
        check("sb_drained", sb.size(), 0);
        finish_sim();
    end

endmodule
